sm_regwrite_arbiter: RTL and testbench
======================================

Name: sm_regwrite_arbiter

Overview:
- Round-robin arbiter sharing one write port of the register bank (an array of 32-bit write-enabled registers) between NREQ requesters, e.g. core writeback, load unit and debug port.
- Each requester presents a valid/ready write request. The winner is registered onto a single we/addr/data write bus.
- Supports locked bursts and a downstream stall.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester write request.
- req_lock  in  NREQ  per-requester burst lock; sampled with valid.
- req_addr  in  NREQ*AW  packed addresses; requester i at bits [i*AW +: AW].
- req_data  in  NREQ*DW  packed data; requester i at bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot accept, combinational.
- wr_stall  in  1  downstream cannot take a write this cycle.
- wr_we  out  1  registered write enable to the bank.
- wr_addr  out  AW  registered write address.
- wr_data  out  DW  registered write data.
- grant_id  out  3  index of the requester that produced the current wr_* beat.

Behaviour:
- Reset (asynchronous, immediate) clears:
  - wr_we, wr_addr, wr_data, grant_id to 0.
  - The round-robin pointer to 0 (requester 0 highest priority first).
  - The FSM to ARB.
- Transfer:
  - A transfer occurs in a cycle where req_valid[i] && req_ready[i].
  - req_ready is all-zero while wr_stall=1.
  - At most one req_ready bit is high per cycle.
- Latency:
  - An accepted request appears on wr_* at the next rising edge, so wr_we is high for exactly one cycle per accepted request.
  - With no transfer and wr_stall=0, wr_we=0 at the next edge; wr_addr and wr_data hold their values.
- Stall:
  - While wr_stall=1, all wr_* outputs and grant_id hold their values, including wr_we.
  - A beat held by stall is not repeated once wr_stall drops; the bank sees the same beat while stalled.
- Register x0 drop:
  - A request with req_addr==0 is accepted (ready asserted) and updates the RR pointer.
  - The next-cycle wr_we is forced to 0, so x0 is never written.
- FSM state ARB:
  - Grant goes to the first valid requester searching from the RR pointer upward, modulo NREQ.
  - On transfer, the pointer becomes (winner+1) mod NREQ.
  - If the winner's req_lock=1, go to LOCKED with owner=winner.
- FSM state LOCKED:
  - Only the owner can be granted; all other req_ready bits are 0.
  - Stay while the owner's req_lock=1, whether or not its valid is high; other requesters wait.
  - When a transfer occurs with the owner's lock=0, or the owner's lock drops while idle, return to ARB at the next edge.
  - The pointer is not advanced during LOCKED transfers except the final one, which sets pointer=owner+1.
- Simultaneous events:
  - Stall outranks everything: no grant and no state change while wr_stall=1.
  - rst outranks stall.
- Reset mid-burst: returns to ARB with the pointer at 0, and no wr_we pulse follows.
- Wrap-around: the pointer after requester NREQ-1 is 0.

Optional Feature:
- Macro: SM_ARB_FIXED_PRIO_EN.
- Defined: ARB always searches from requester 0 (lowest index wins). The pointer register is not implemented; LOCKED behaviour is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst mid-cycle with req_valid=3'b111.
  - Response: wr_we=0 immediately; after release, the first grant goes to requester 0.
- Round-robin:
  - Stimulus: all three valid continuously, lock=0, addrs 1/2/3, data 0xA/0xB/0xC.
  - Response: wr_we=1 every cycle; grant_id sequence 0,1,2,0; wr_data 0xA,0xB,0xC,0xA.
- Stall:
  - Stimulus: raise wr_stall for 3 cycles after the first grant.
  - Response: req_ready=0, wr_* hold (addr 1, data 0xA, we=1) for 3 cycles, then grant_id=1.
- x0 drop:
  - Stimulus: requester 1 only, addr 0, data 0xDEAD.
  - Response: req_ready[1]=1, next cycle wr_we=0; the next requester-1 write to addr 5 gives wr_we=1.
- Locked burst:
  - Stimulus: requester 2 with lock=1 for 4 beats, requesters 0 and 1 valid throughout.
  - Response: grant_id=2 for 4 beats with lock, then the final unlocked beat, then grant_id=0.
- Fixed priority (SM_ARB_FIXED_PRIO_EN):
  - Stimulus: the round-robin stimulus above.
  - Response: grant_id stays 0 every cycle.

Source files
------------

// File: rtl/sm_regwrite_arbiter_if.sv
// Write-request bundle between NREQ requesters and the shared register-bank write port.
// The master side drives the requests and the stall; the slave side (the arbiter) drives ready and the write bus.
interface sm_regwrite_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               wr_stall;
    logic               wr_we;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic [2:0]         grant_id;

    modport master (
        output req_valid, req_lock, req_addr, req_data, wr_stall,
        input  req_ready, wr_we, wr_addr, wr_data, grant_id
    );

    modport slave (
        input  req_valid, req_lock, req_addr, req_data, wr_stall,
        output req_ready, wr_we, wr_addr, wr_data, grant_id
    );
endinterface

// File: rtl/sm_regwrite_arbiter.sv
// Round-robin arbiter for one register-bank write port, with locked bursts, x0 drop and downstream stall.
// Define SM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); the pointer register is then omitted.
module sm_regwrite_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    sm_regwrite_arbiter_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {ARB, LOCKED} state_t;

    state_t        state;
    logic [IW-1:0] owner;
    logic [IW-1:0] start;

    logic          vld_p1;
    logic [AW-1:0] addr_p1;
    logic [DW-1:0] data_p1;
    logic [2:0]    gid_p1;

    logic          gnt_any;
    logic [IW-1:0] gnt_idx;
    logic [IW:0]   pick;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic [NREQ-1:0] ready;

`ifdef SM_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [IW-1:0] ptr;
    assign start = ptr;
`endif

    // First valid requester at or after start, wrapping; returns {found, index}.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IW-1:0] s);
        logic [IW:0] r;
        int          idx;
        r = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(s) + k) % NREQ;
            if (v[idx]) r = {1'b1, IW'(idx)};
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (int'(i) + 1 == NREQ) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        pick    = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (state == LOCKED) begin
            gnt_any = bus.req_valid[owner];
            gnt_idx = owner;
        end else begin
            pick    = rr_pick(bus.req_valid, start);
            gnt_any = pick[IW];
            gnt_idx = pick[IW-1:0];
        end
        if (bus.wr_stall) gnt_any = 1'b0;
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == gnt_idx) begin
                sel_addr = bus.req_addr[i*AW +: AW];
                sel_data = bus.req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (gnt_any) ready[gnt_idx] = 1'b1;
    end

    assign bus.req_ready = ready;

    // p0 -> p1: registered write beat; stall freezes the beat and all arbitration state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB;
            owner   <= '0;
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            gid_p1  <= '0;
`ifndef SM_ARB_FIXED_PRIO_EN
            ptr     <= '0;
`endif
        end else if (!bus.wr_stall) begin
            vld_p1 <= gnt_any && (sel_addr != '0);
            if (gnt_any) begin
                addr_p1 <= sel_addr;
                data_p1 <= sel_data;
                gid_p1  <= 3'(gnt_idx);
            end
            case (state)
                ARB: begin
                    if (gnt_any) begin
`ifndef SM_ARB_FIXED_PRIO_EN
                        ptr <= next_idx(gnt_idx);
`endif
                        if (bus.req_lock[gnt_idx]) begin
                            state <= LOCKED;
                            owner <= gnt_idx;
                        end
                    end
                end
                LOCKED: begin
                    // Lock released: either the final beat goes out now or the owner has gone idle.
                    if (!bus.req_lock[owner]) begin
                        state <= ARB;
`ifndef SM_ARB_FIXED_PRIO_EN
                        if (gnt_any) ptr <= next_idx(owner);
`endif
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    assign bus.wr_we    = vld_p1;
    assign bus.wr_addr  = addr_p1;
    assign bus.wr_data  = data_p1;
    assign bus.grant_id = gid_p1;

endmodule

// File: tb/tb_sm_regwrite_arbiter.sv
// Directed bench for sm_regwrite_arbiter: reset, round-robin, stall, x0 drop and locked bursts.
module tb_sm_regwrite_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic clk;
    logic rst;
    logic stall;
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] l;
    logic [AW-1:0]   a [NREQ];
    logic [DW-1:0]   d [NREQ];

    int checks;
    int errors;

    sm_regwrite_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    sm_regwrite_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.req_valid = v;
        bus.req_lock  = l;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*AW +: AW] = a[i];
            bus.req_data[i*DW +: DW] = d[i];
        end
    end

    assign bus.wr_stall = stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic val, input logic lk,
                           input logic [AW-1:0] ad, input logic [DW-1:0] dt);
        v[i] = val;
        l[i] = lk;
        a[i] = ad;
        d[i] = dt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        stall  = 1'b0;
        v      = '0;
        l      = '0;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
        tick();
        tick();
        chk("reset_we",    32'(bus.wr_we), 0);
        chk("reset_addr",  32'(bus.wr_addr), 0);
        chk("reset_data",  32'(bus.wr_data), 0);
        chk("reset_gid",   32'(bus.grant_id), 0);
        chk("reset_ready", 32'(bus.req_ready), 0);
        rst = 1'b0;

`ifndef SM_ARB_FIXED_PRIO_EN
        set_req(0, 1'b1, 1'b0, 5'd1, 32'hA);
        set_req(1, 1'b1, 1'b0, 5'd2, 32'hB);
        set_req(2, 1'b1, 1'b0, 5'd3, 32'hC);
        #1;
        chk("idle_ready", 32'(bus.req_ready), 32'h1);
        tick();
        chk("pre_rst_we",  32'(bus.wr_we), 1);
        chk("pre_rst_gid", 32'(bus.grant_id), 0);

        #3 rst = 1'b1;
        #1;
        chk("async_rst_we",   32'(bus.wr_we), 0);
        chk("async_rst_data", 32'(bus.wr_data), 0);
        chk("async_rst_gid",  32'(bus.grant_id), 0);
        tick();
        chk("rst_hold_we", 32'(bus.wr_we), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'h1);

        tick();
        chk("rr0_gid",  32'(bus.grant_id), 0);
        chk("rr0_data", 32'(bus.wr_data), 32'hA);
        chk("rr0_we",   32'(bus.wr_we), 1);
        tick();
        chk("rr1_gid",  32'(bus.grant_id), 1);
        chk("rr1_data", 32'(bus.wr_data), 32'hB);
        chk("rr1_we",   32'(bus.wr_we), 1);
        tick();
        chk("rr2_gid",  32'(bus.grant_id), 2);
        chk("rr2_data", 32'(bus.wr_data), 32'hC);
        chk("rr2_we",   32'(bus.wr_we), 1);
        tick();
        chk("rr3_gid",  32'(bus.grant_id), 0);
        chk("rr3_data", 32'(bus.wr_data), 32'hA);
        chk("rr3_addr", 32'(bus.wr_addr), 1);
        chk("rr3_we",   32'(bus.wr_we), 1);

        stall = 1'b1;
        #1;
        chk("stall_ready", 32'(bus.req_ready), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_we",    32'(bus.wr_we), 1);
            chk("stall_addr",  32'(bus.wr_addr), 1);
            chk("stall_data",  32'(bus.wr_data), 32'hA);
            chk("stall_gid",   32'(bus.grant_id), 0);
            chk("stall_ready", 32'(bus.req_ready), 0);
        end
        stall = 1'b0;
        #1;
        chk("unstall_ready", 32'(bus.req_ready), 32'h2);
        tick();
        chk("unstall_gid",  32'(bus.grant_id), 1);
        chk("unstall_data", 32'(bus.wr_data), 32'hB);

        set_req(0, 1'b0, 1'b0, 5'd0, 32'h0);
        set_req(2, 1'b0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b1, 1'b0, 5'd0, 32'hDEAD);
        #1;
        chk("x0_ready", 32'(bus.req_ready), 32'h2);
        tick();
        chk("x0_we", 32'(bus.wr_we), 0);
        set_req(1, 1'b1, 1'b0, 5'd5, 32'h55);
        #1;
        chk("x5_ready", 32'(bus.req_ready), 32'h2);
        tick();
        chk("x5_we",   32'(bus.wr_we), 1);
        chk("x5_addr", 32'(bus.wr_addr), 5);
        chk("x5_data", 32'(bus.wr_data), 32'h55);
        chk("x5_gid",  32'(bus.grant_id), 1);

        set_req(1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("idle_we",   32'(bus.wr_we), 0);
        chk("idle_addr", 32'(bus.wr_addr), 5);
        chk("idle_data", 32'(bus.wr_data), 32'h55);

        set_req(0, 1'b1, 1'b0, 5'd1, 32'hA);
        set_req(1, 1'b1, 1'b0, 5'd2, 32'hB);
        for (int k = 0; k < 4; k++) begin
            set_req(2, 1'b1, 1'b1, 5'd7, 32'h70 + 32'(k));
            #1;
            chk("lock_ready", 32'(bus.req_ready), 32'h4);
            tick();
            chk("lock_gid",  32'(bus.grant_id), 2);
            chk("lock_data", 32'(bus.wr_data), 32'h70 + 32'(k));
            chk("lock_we",   32'(bus.wr_we), 1);
        end
        set_req(2, 1'b1, 1'b0, 5'd7, 32'h7F);
        #1;
        chk("lock_last_ready", 32'(bus.req_ready), 32'h4);
        tick();
        chk("lock_last_gid",  32'(bus.grant_id), 2);
        chk("lock_last_data", 32'(bus.wr_data), 32'h7F);
        chk("after_lock_ready", 32'(bus.req_ready), 32'h1);
        tick();
        chk("after_lock_gid",  32'(bus.grant_id), 0);
        chk("after_lock_data", 32'(bus.wr_data), 32'hA);

        set_req(1, 1'b0, 1'b0, 5'd0, 32'h0);
        set_req(2, 1'b0, 1'b0, 5'd0, 32'h0);
        set_req(0, 1'b1, 1'b1, 5'd1, 32'hA0);
        #1;
        chk("lk0_ready", 32'(bus.req_ready), 32'h1);
        tick();
        chk("lk0_gid",  32'(bus.grant_id), 0);
        chk("lk0_data", 32'(bus.wr_data), 32'hA0);
        set_req(0, 1'b0, 1'b1, 5'd1, 32'hA0);
        set_req(1, 1'b1, 1'b0, 5'd2, 32'hB0);
        #1;
        chk("lk_wait_ready", 32'(bus.req_ready), 0);
        tick();
        chk("lk_wait_we", 32'(bus.wr_we), 0);
        set_req(0, 1'b0, 1'b0, 5'd1, 32'hA0);
        #1;
        chk("lk_drop_ready", 32'(bus.req_ready), 0);
        tick();
        chk("lk_released_ready", 32'(bus.req_ready), 32'h2);
        tick();
        chk("lk_released_gid",  32'(bus.grant_id), 1);
        chk("lk_released_data", 32'(bus.wr_data), 32'hB0);
`else
        set_req(0, 1'b1, 1'b0, 5'd1, 32'hA);
        set_req(1, 1'b1, 1'b0, 5'd2, 32'hB);
        set_req(2, 1'b1, 1'b0, 5'd3, 32'hC);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fp_ready", 32'(bus.req_ready), 32'h1);
            tick();
            chk("fp_gid",  32'(bus.grant_id), 0);
            chk("fp_data", 32'(bus.wr_data), 32'hA);
            chk("fp_we",   32'(bus.wr_we), 1);
        end
        set_req(0, 1'b0, 1'b0, 5'd1, 32'hA);
        #1;
        chk("fp_next_ready", 32'(bus.req_ready), 32'h2);
        tick();
        chk("fp_next_gid", 32'(bus.grant_id), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
